// File: rtl/modem_pkg.sv
// ============================================================================
// modem_pkg : shared types and sizing helpers for the multimode modem core
// Rev 1.0
// ============================================================================
`default_nettype none

package modem_pkg;

    typedef enum logic [1:0] {
        MODE_OOK  = 2'd0,
        MODE_BPSK = 2'd1,
        MODE_BFSK = 2'd2,
        MODE_TONE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_TONE = 2'd2
    } state_e;

    function automatic int mid_of(input int dw);
        return 2 ** (dw - 1);
    endfunction

    // Sized so SPS full-scale samples plus sign never overflow.
    function automatic int acc_w_of(input int dw, input int sps);
        return dw + $clog2(sps) + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/modem_multimode_core_sine_lut.sv
// ============================================================================
// sine_lut : quarter-wave sine table with quadrant folding, offset-binary out
// Rev 1.0
// ============================================================================
`default_nettype none

module sine_lut
    import modem_pkg::*;
#(
    parameter int DATA_W = 7,
    parameter int LUT_AW = 5
) (
    input  logic [LUT_AW+1:0] i_phase,
    output logic [DATA_W-1:0] o_sample
);

    localparam int c_MID = mid_of(DATA_W);

    // 63*sin(pi/2*(a+0.5)/32): half-step offset keeps folded quadrants mirror-exact.
    function automatic logic [5:0] qsine63(input logic [4:0] idx);
        logic [5:0] v;
        case (idx)
            5'd0:  v = 6'd2;   5'd1:  v = 6'd5;   5'd2:  v = 6'd8;   5'd3:  v = 6'd11;
            5'd4:  v = 6'd14;  5'd5:  v = 6'd17;  5'd6:  v = 6'd20;  5'd7:  v = 6'd23;
            5'd8:  v = 6'd26;  5'd9:  v = 6'd28;  5'd10: v = 6'd31;  5'd11: v = 6'd34;
            5'd12: v = 6'd36;  5'd13: v = 6'd39;  5'd14: v = 6'd41;  5'd15: v = 6'd43;
            5'd16: v = 6'd46;  5'd17: v = 6'd48;  5'd18: v = 6'd50;  5'd19: v = 6'd52;
            5'd20: v = 6'd53;  5'd21: v = 6'd55;  5'd22: v = 6'd56;  5'd23: v = 6'd58;
            5'd24: v = 6'd59;  5'd25: v = 6'd60;  5'd26: v = 6'd61;  5'd27: v = 6'd61;
            5'd28: v = 6'd62;  5'd29: v = 6'd63;  5'd30: v = 6'd63;  default: v = 6'd63;
        endcase
        return v;
    endfunction

    logic [1:0]        w_quad;
    logic [LUT_AW-1:0] w_addr;
    logic [4:0]        w_idx;
    logic [5:0]        w_tab;
    int                w_amp;

    assign w_quad = i_phase[LUT_AW+1 -: 2];
    assign w_addr = w_quad[0] ? ~i_phase[LUT_AW-1:0] : i_phase[LUT_AW-1:0];

    generate
        if (LUT_AW >= 5) begin : g_idx_trunc
            assign w_idx = w_addr[LUT_AW-1 -: 5];
        end else begin : g_idx_pad
            assign w_idx = {w_addr, {(5 - LUT_AW){1'b0}}};
        end
    endgenerate

    assign w_tab = qsine63(w_idx);

    always_comb begin
        w_amp    = (int'(w_tab) * (c_MID - 1) + 31) / 63;
        o_sample = w_quad[1] ? DATA_W'(c_MID - w_amp) : DATA_W'(c_MID + w_amp);
    end

endmodule

`default_nettype wire

// File: rtl/modem_multimode_core.sv
// ============================================================================
// modem_multimode_core : OOK/BPSK/BFSK/tone byte modulator with NCO carrier
// and a coherent integrate-and-dump demodulator slaved to the TX symbol timing.
// Rev 1.0
// ============================================================================
`default_nettype none

module modem_multimode_core
    import modem_pkg::*;
#(
    parameter int DATA_W  = 7,
    parameter int PHASE_W = 12,
    parameter int LUT_AW  = 5,
    parameter int SPS     = 16,
    parameter int F0_INC  = 256,
    parameter int F1_INC  = 512,
    parameter int OOK_THR = SPS * (2 ** (DATA_W - 1)) / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [7:0]        tx_data,
    output logic [DATA_W-1:0] mod_out,
    output logic              busy,
    input  logic [DATA_W-1:0] rx_in,
    output logic              demod_bit,
    output logic              demod_valid
);

    localparam int c_MID   = mid_of(DATA_W);
    localparam int c_ACC_W = acc_w_of(DATA_W, SPS);
    localparam int c_CNT_W = $clog2(SPS);
    localparam logic [PHASE_W-1:0] c_F0    = PHASE_W'(F0_INC);
    localparam logic [PHASE_W-1:0] c_F1    = PHASE_W'(F1_INC);
    localparam logic [DATA_W-1:0]  c_MID_S = DATA_W'(c_MID);
    localparam logic [DATA_W-1:0]  c_FULL  = DATA_W'(2 * c_MID - 1);
    localparam logic signed [c_ACC_W-1:0] c_ZERO = '0;
    localparam logic signed [c_ACC_W-1:0] c_THR  = c_ACC_W'(OOK_THR);

    state_e               r_state, w_next;
    mode_e                r_mode, r_dmode;
    logic                 r_up;
    logic [7:0]           r_byte;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_bit;
    logic [PHASE_W-1:0]   r_ph, r_p0, r_p1;
    logic [DATA_W-1:0]    r_mod;
    logic                 r_dv, r_last, r_r0, r_r1;
    logic signed [c_ACC_W-1:0] r_e, r_c0, r_c1;
    logic                 r_dbit, r_dval;

    logic                 w_tone_req, w_sym_end, w_byte_end, w_cur_bit, w_ready, w_accept;
    logic [PHASE_W-1:0]   w_inc;
    logic [DATA_W-1:0]    w_sine, w_sample;
    logic signed [DATA_W:0]    w_x;
    logic signed [c_ACC_W-1:0] w_xe, w_e_n, w_c0_n, w_c1_n, w_a0, w_a1;
    logic                 w_decide;

    assign w_tone_req = (mode_e'(sel) == MODE_TONE);
    assign w_sym_end  = (r_cnt == c_CNT_W'(SPS - 1));
    assign w_byte_end = w_sym_end && (r_bit == 3'd7);
    assign w_cur_bit  = r_byte[r_bit];
    assign w_accept   = w_ready && tx_valid;

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = r_up && !w_tone_req;
                if (w_ready && tx_valid)      w_next = ST_SEND;
                else if (r_up && w_tone_req)  w_next = ST_TONE;
            end
            ST_SEND: begin
                // Ready on the last cycle of bit 7 lets the next byte follow gap-free.
                if (w_byte_end) begin
                    w_ready = !w_tone_req;
                    if (!(w_ready && tx_valid)) w_next = ST_IDLE;
                end
            end
            ST_TONE: if (!w_tone_req) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_inc = (r_state == ST_SEND && r_mode == MODE_BFSK && w_cur_bit) ? c_F1 : c_F0;

    sine_lut #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_sine_lut (
        .i_phase  (r_ph[PHASE_W-1 -: LUT_AW+2]),
        .o_sample (w_sine)
    );

    always_comb begin
        w_sample = c_MID_S;
        if (r_state == ST_TONE) begin
            w_sample = w_sine;
        end else if (r_state == ST_SEND) begin
            case (r_mode)
                MODE_OOK:  w_sample = w_cur_bit ? w_sine : c_MID_S;
                MODE_BPSK: w_sample = w_cur_bit ? w_sine : c_FULL - w_sine;
                default:   w_sample = w_sine;
            endcase
        end
    end

    // Demod pipeline runs one cycle behind the FSM, aligned with registered mod_out.
    assign w_x    = $signed({1'b0, rx_in}) - $signed((DATA_W + 1)'(c_MID));
    assign w_xe   = c_ACC_W'(w_x);
    assign w_e_n  = r_e  + (w_x[DATA_W] ? -w_xe : w_xe);
    assign w_c0_n = r_c0 + (r_r0 ? -w_xe : w_xe);
    assign w_c1_n = r_c1 + (r_r1 ? -w_xe : w_xe);
    assign w_a0   = w_c0_n[c_ACC_W-1] ? -w_c0_n : w_c0_n;
    assign w_a1   = w_c1_n[c_ACC_W-1] ? -w_c1_n : w_c1_n;

    always_comb begin
        w_decide = 1'b0;
        case (r_dmode)
            MODE_OOK:  w_decide = (w_e_n > c_THR);
            MODE_BPSK: w_decide = (w_c0_n > c_ZERO);
            MODE_BFSK: w_decide = (w_a1 > w_a0);
            default:   w_decide = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_OOK;
            r_dmode <= MODE_OOK;
            r_up    <= 1'b0;
            r_byte  <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_ph    <= '0;
            r_p0    <= '0;
            r_p1    <= '0;
            r_mod   <= c_MID_S;
            r_dv    <= 1'b0;
            r_last  <= 1'b0;
            r_r0    <= 1'b0;
            r_r1    <= 1'b0;
            r_e     <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
            r_dbit  <= 1'b0;
            r_dval  <= 1'b0;
        end else begin
            r_up    <= 1'b1;
            r_state <= w_next;
            r_mod   <= w_sample;

            if (w_accept) begin
                r_byte <= tx_data;
                r_mode <= mode_e'(sel);
                r_cnt  <= '0;
                r_bit  <= '0;
            end else if (r_state == ST_SEND) begin
                if (w_sym_end) begin
                    r_cnt <= '0;
                    r_bit <= r_bit + 3'd1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            if (w_next == ST_IDLE) begin
                r_ph <= '0;
                r_p0 <= '0;
                r_p1 <= '0;
            end else if (r_state != ST_IDLE) begin
                r_ph <= r_ph + w_inc;
                r_p0 <= r_p0 + c_F0;
                r_p1 <= r_p1 + c_F1;
            end

            r_dv    <= (r_state == ST_SEND);
            r_last  <= w_sym_end;
            r_r0    <= r_p0[PHASE_W-1];
            r_r1    <= r_p1[PHASE_W-1];
            r_dmode <= r_mode;
            r_dval  <= 1'b0;
            if (r_dv) begin
                if (r_last) begin
                    r_dbit <= w_decide;
                    r_dval <= 1'b1;
                    r_e    <= '0;
                    r_c0   <= '0;
                    r_c1   <= '0;
                end else begin
                    r_e    <= w_e_n;
                    r_c0   <= w_c0_n;
                    r_c1   <= w_c1_n;
                end
            end
        end
    end

    assign tx_ready    = w_ready;
    assign busy        = (r_state == ST_SEND);
    assign mod_out     = r_mod;
    assign demod_bit   = r_dbit;
    assign demod_valid = r_dval;

endmodule

`default_nettype wire
